// File: rtl/trace_filter_multi.sv
// rtl/trace_filter_multi.sv - retired-instruction trace filter with class enables, post-event window and registered output
module trace_filter_multi #(
    parameter int INSTR_WIDTH    = 32,
    parameter int PC_WIDTH       = 64,
    parameter int POST_CNT_WIDTH = 4,
    parameter int STAT_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [PC_WIDTH-1:0]       in_pc,
    input  logic [INSTR_WIDTH-1:0]    in_instr,
    input  logic [3:0]                class_enable,
    input  logic [3:0]                post_enable,
    input  logic [POST_CNT_WIDTH-1:0] post_count,
    input  logic                      bypass,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PC_WIDTH-1:0]       out_pc,
    output logic [INSTR_WIDTH-1:0]    out_instr,
    output logic [3:0]                out_class,
    output logic                      out_post,
    output logic [STAT_WIDTH-1:0]     kept_count,
    output logic [STAT_WIDTH-1:0]     lost_count
);

    localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

    logic [3:0]                cls;
    logic                      is_event;
    logic                      opens_window;
    logic                      in_window;
    logic                      keep;
    logic                      capture;
    logic                      lose;

    logic [POST_CNT_WIDTH-1:0] win_cnt_q, win_cnt_d;
    logic                      out_valid_q, out_valid_d;
    logic [PC_WIDTH-1:0]       out_pc_q, out_pc_d;
    logic [INSTR_WIDTH-1:0]    out_instr_q, out_instr_d;
    logic [3:0]                out_class_q, out_class_d;
    logic                      out_post_q, out_post_d;
    logic [STAT_WIDTH-1:0]     kept_q, kept_d;
    logic [STAT_WIDTH-1:0]     lost_q, lost_d;

    // Compressed forms only match when [1:0]!=11, so they never alias the 32-bit opcodes.
    always_comb begin
        cls    = 4'b0000;
        cls[0] = (in_instr[6:0] == 7'b1100011) ||
                 (in_instr[1:0] == 2'b01 && in_instr[15:14] == 2'b11);
        cls[1] = (in_instr[6:0] == 7'b1101111) || (in_instr[6:0] == 7'b1100111) ||
                 (in_instr[1:0] == 2'b01 &&
                  (in_instr[15:13] == 3'b001 || in_instr[15:13] == 3'b101)) ||
                 (in_instr[1:0] == 2'b10 && in_instr[15:13] == 3'b100 &&
                  in_instr[6:2] == 5'd0 && in_instr[11:7] != 5'd0);
        cls[2] = (in_instr[31:0] == 32'h10500073);
        cls[3] = (in_instr[31:0] == 32'h30200073) || (in_instr[31:0] == 32'h10200073);
    end

    always_comb begin
        is_event     = |(cls & class_enable);
        opens_window = is_event && (|(cls & post_enable));
        in_window    = (win_cnt_q != '0) && !is_event;
        keep         = in_valid && (bypass || is_event || in_window);
        capture      = keep && (!out_valid_q || out_ready);
        lose         = keep && out_valid_q && !out_ready;
    end

    always_comb begin
        win_cnt_d   = win_cnt_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        out_class_d = out_class_q;
        out_post_d  = out_post_q;
        kept_d      = kept_q;
        lost_d      = lost_q;

        // Window bookkeeping runs on every valid instruction, bypass or not.
        if (in_valid) begin
            if (opens_window) begin
                win_cnt_d = post_count;
            end else if (in_window) begin
                win_cnt_d = win_cnt_q - POST_CNT_WIDTH'(1);
            end
        end

        if (capture) begin
            out_valid_d = 1'b1;
            out_pc_d    = in_pc;
            out_instr_d = in_instr;
            out_class_d = is_event ? cls : 4'b0000;
            out_post_d  = in_window;
            if (kept_q != STAT_MAX) begin
                kept_d = kept_q + STAT_WIDTH'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (lose && lost_q != STAT_MAX) begin
            lost_d = lost_q + STAT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
            out_class_q <= 4'b0000;
            out_post_q  <= 1'b0;
            kept_q      <= '0;
            lost_q      <= '0;
        end else begin
            win_cnt_q   <= win_cnt_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
            out_class_q <= out_class_d;
            out_post_q  <= out_post_d;
            kept_q      <= kept_d;
            lost_q      <= lost_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_pc     = out_pc_q;
    assign out_instr  = out_instr_q;
    assign out_class  = out_class_q;
    assign out_post   = out_post_q;
    assign kept_count = kept_q;
    assign lost_count = lost_q;

endmodule

// File: tb/tb_trace_filter_multi.sv
// tb/tb_trace_filter_multi.sv - directed self-checking bench for trace_filter_multi
module tb_trace_filter_multi;

    localparam logic [31:0] ADDI  = 32'h00108093;
    localparam logic [31:0] BEQ   = 32'h00000063;
    localparam logic [31:0] WFI   = 32'h10500073;
    localparam logic [31:0] MRET  = 32'h30200073;
    localparam logic [31:0] CBNEZ = 32'h0000E001;
    localparam logic [31:0] CJ    = 32'h0000A001;
    localparam logic [31:0] CJALR = 32'h00009082;
    localparam logic [31:0] CJR0  = 32'h00008002;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_pc;
    logic [31:0] in_instr;
    logic [3:0]  class_enable;
    logic [3:0]  post_enable;
    logic [3:0]  post_count;
    logic        bypass;
    logic        out_ready;

    logic        out_valid,   s_out_valid;
    logic [63:0] out_pc,      s_out_pc;
    logic [31:0] out_instr,   s_out_instr;
    logic [3:0]  out_class,   s_out_class;
    logic        out_post,    s_out_post;
    logic [31:0] kept_count,  lost_count;
    logic [1:0]  s_kept_count, s_lost_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    trace_filter_multi dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .class_enable(class_enable), .post_enable(post_enable), .post_count(post_count),
        .bypass(bypass), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .out_class(out_class), .out_post(out_post),
        .kept_count(kept_count), .lost_count(lost_count)
    );

    trace_filter_multi #(.STAT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .class_enable(class_enable), .post_enable(post_enable), .post_count(post_count),
        .bypass(bypass), .out_valid(s_out_valid), .out_ready(out_ready), .out_pc(s_out_pc),
        .out_instr(s_out_instr), .out_class(s_out_class), .out_post(s_out_post),
        .kept_count(s_kept_count), .lost_count(s_lost_count)
    );

    task automatic step(input logic v, input logic [31:0] instr, input logic [63:0] pc);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        class_enable = 4'b0000; post_enable = 4'b0000; post_count = 4'd0;
        bypass = 1'b0; out_ready = 1'b1; in_instr = '0; in_pc = '0;
        do_reset();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_checks++;
        if (kept_count !== 32'd0 || lost_count !== 32'd0) begin
            n_fail++; $display("FAIL reset_counts got kept=%0d lost=%0d want 0/0", kept_count, lost_count);
        end
        n_checks++;
        if (out_pc !== 64'd0 || out_class !== 4'd0 || out_post !== 1'b0) begin
            n_fail++; $display("FAIL reset_out got pc=%h class=%b post=%b want 0", out_pc, out_class, out_post);
        end
    endtask

    task automatic test_window_reload();
        logic [31:0] ins [6];
        logic        ev  [6];
        logic [3:0]  ec  [6];
        logic        ep  [6];
        do_reset();
        class_enable = 4'b0001; post_enable = 4'b0001; post_count = 4'd2; out_ready = 1'b1;
        ins = '{ADDI, BEQ, ADDI, ADDI, ADDI, ADDI};
        ev  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        ec  = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        ep  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, ins[i], 64'h100 + 64'(4 * i));
            n_checks++;
            if (out_valid !== ev[i] || (ev[i] && (out_class !== ec[i] || out_post !== ep[i] ||
                out_pc !== 64'h100 + 64'(4 * i)))) begin
                n_fail++;
                $display("FAIL window_step%0d got v=%b c=%b p=%b pc=%h want v=%b c=%b p=%b",
                         i, out_valid, out_class, out_post, out_pc, ev[i], ec[i], ep[i]);
            end
        end
        n_checks++;
        if (kept_count !== 32'd3) begin n_fail++; $display("FAIL window_kept got %0d want 3", kept_count); end

        do_reset();
        ins = '{BEQ, ADDI, BEQ, ADDI, ADDI, ADDI};
        ev  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, ins[i], 64'h200 + 64'(4 * i));
            n_checks++;
            if (out_valid !== ev[i]) begin
                n_fail++; $display("FAIL reload_step%0d got v=%b want %b", i, out_valid, ev[i]);
            end
        end
        n_checks++;
        if (kept_count !== 32'd5) begin n_fail++; $display("FAIL reload_kept got %0d want 5", kept_count); end

        do_reset();
        post_count = 4'd0;
        step(1'b1, BEQ, 64'h300);
        step(1'b1, ADDI, 64'h304);
        n_checks++;
        if (out_valid !== 1'b0 || kept_count !== 32'd1) begin
            n_fail++; $display("FAIL post_zero got v=%b kept=%0d want 0/1", out_valid, kept_count);
        end
    endtask

    task automatic test_compressed();
        logic [31:0] ins [5];
        logic        ev  [5];
        logic [3:0]  ec  [5];
        do_reset();
        class_enable = 4'b1111; post_enable = 4'b0000; post_count = 4'd3; out_ready = 1'b1;
        ins = '{CBNEZ, CJ, CJALR, CJR0, WFI};
        ev  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        ec  = '{4'b0001, 4'b0010, 4'b0010, 4'b0000, 4'b0100};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, ins[i], 64'h400 + 64'(2 * i));
            n_checks++;
            if (out_valid !== ev[i] || (ev[i] && out_class !== ec[i])) begin
                n_fail++;
                $display("FAIL compressed%0d got v=%b c=%b want v=%b c=%b", i, out_valid, out_class, ev[i], ec[i]);
            end
        end
    endtask

    task automatic test_xret();
        do_reset();
        class_enable = 4'b1111; post_enable = 4'b0000; post_count = 4'd3; out_ready = 1'b1;
        step(1'b1, MRET, 64'h500);
        n_checks++;
        if (out_valid !== 1'b1 || out_class !== 4'b1000) begin
            n_fail++; $display("FAIL xret_class got v=%b c=%b want 1/1000", out_valid, out_class);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, ADDI, 64'h504 + 64'(4 * i));
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL xret_after%0d got v=%b want 0", i, out_valid); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        class_enable = 4'b0001; post_enable = 4'b0000; post_count = 4'd0; out_ready = 1'b0;
        step(1'b1, BEQ, 64'hA0);
        step(1'b1, BEQ, 64'hA4);
        step(1'b1, BEQ, 64'hA8);
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'hA0) begin
            n_fail++; $display("FAIL bp_hold got v=%b pc=%h want 1/a0", out_valid, out_pc);
        end
        n_checks++;
        if (kept_count !== 32'd1 || lost_count !== 32'd2) begin
            n_fail++; $display("FAIL bp_counts got kept=%0d lost=%0d want 1/2", kept_count, lost_count);
        end
        out_ready = 1'b1;
        step(1'b1, BEQ, 64'hAC);
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'hAC || kept_count !== 32'd2 || lost_count !== 32'd2) begin
            n_fail++; $display("FAIL bp_b2b got v=%b pc=%h kept=%0d lost=%0d want 1/ac/2/2",
                               out_valid, out_pc, kept_count, lost_count);
        end
        step(1'b0, ADDI, 64'hB0);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got v=%b want 0", out_valid); end
    endtask

    task automatic test_bypass_gap();
        logic vin [6];
        logic ev  [6];
        do_reset();
        class_enable = 4'b0000; post_enable = 4'b0000; post_count = 4'd0; bypass = 1'b1; out_ready = 1'b1;
        step(1'b1, ADDI, 64'h600);
        n_checks++;
        if (out_valid !== 1'b1 || out_class !== 4'd0) begin
            n_fail++; $display("FAIL bypass0 got v=%b c=%b want 1/0000", out_valid, out_class);
        end
        step(1'b0, ADDI, 64'h604);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bypass1 got v=%b want 0", out_valid); end
        step(1'b1, ADDI, 64'h608);
        n_checks++;
        if (out_valid !== 1'b1 || kept_count !== 32'd2) begin
            n_fail++; $display("FAIL bypass2 got v=%b kept=%0d want 1/2", out_valid, kept_count);
        end

        bypass = 1'b0; class_enable = 4'b0001; post_enable = 4'b0001; post_count = 4'd2;
        do_reset();
        vin = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        ev  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            step(vin[i], (i == 0) ? BEQ : ADDI, 64'h700 + 64'(4 * i));
            n_checks++;
            if (out_valid !== ev[i] || (i == 4 && out_post !== 1'b1)) begin
                n_fail++; $display("FAIL gap_step%0d got v=%b p=%b want v=%b", i, out_valid, out_post, ev[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        class_enable = 4'b0001; post_enable = 4'b0001; post_count = 4'd3; out_ready = 1'b0;
        step(1'b1, BEQ, 64'h800);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre got v=%b want 1", out_valid); end
        do_reset();
        n_checks++;
        if (out_valid !== 1'b0 || kept_count !== 32'd0 || lost_count !== 32'd0) begin
            n_fail++; $display("FAIL midrst_clear got v=%b kept=%0d lost=%0d want 0/0/0",
                               out_valid, kept_count, lost_count);
        end
        out_ready = 1'b1;
        step(1'b1, ADDI, 64'h804);
        n_checks++;
        if (out_valid !== 1'b0 || kept_count !== 32'd0) begin
            n_fail++; $display("FAIL midrst_window got v=%b kept=%0d want 0/0", out_valid, kept_count);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        class_enable = 4'b0001; post_enable = 4'b0000; post_count = 4'd0; out_ready = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b1, BEQ, 64'h900 + 64'(4 * i));
        n_checks++;
        if (s_lost_count !== 2'd3 || s_kept_count !== 2'd1) begin
            n_fail++; $display("FAIL sat_lost got lost=%0d kept=%0d want 3/1", s_lost_count, s_kept_count);
        end
        n_checks++;
        if (lost_count !== 32'd5) begin n_fail++; $display("FAIL wide_lost got %0d want 5", lost_count); end
        step(1'b1, BEQ, 64'h920);
        n_checks++;
        if (s_lost_count !== 2'd3) begin n_fail++; $display("FAIL sat_hold got %0d want 3", s_lost_count); end
    endtask

    initial begin
        test_reset();
        test_window_reload();
        test_compressed();
        test_xret();
        test_backpressure();
        test_bypass_gap();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trace_filter_multi.md
Name: trace_filter_multi

Overview:
- Parametrised successor to the single-instruction trace filter. Classifies each retired instruction into one of four event classes: branch, jump, wfi, xret.
- Keeps only instructions that match an enabled class, plus a runtime-programmable window of N instructions that follow an event.
- Kept instructions go into a registered valid/ready output stage that feeds the trace packer. Kept and lost counts are reported.
- Sits between the CPU trace tap and the trace packer inside continuous_monitoring_system.

Parameters:
- INSTR_WIDTH, 32, instruction width; the compressed decode uses bits [15:0].
- PC_WIDTH, 64, program counter width.
- POST_CNT_WIDTH, 4, width of the post-event window length.
- STAT_WIDTH, 32, width of the kept and lost statistics counters.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  in_pc/in_instr describe a retired instruction this cycle
- in_pc  input  PC_WIDTH  PC of the retired instruction
- in_instr  input  INSTR_WIDTH  retired instruction encoding
- class_enable  input  4  per-class keep enable; bit0 branch, bit1 jump, bit2 wfi, bit3 xret
- post_enable  input  4  per-class enable for opening a post-event window
- post_count  input  POST_CNT_WIDTH  number of instructions kept after an event
- bypass  input  1  keep every valid instruction, ignoring the class logic
- out_valid  output  1  output register holds a kept instruction
- out_ready  input  1  downstream accepts the output this cycle
- out_pc  output  PC_WIDTH  PC of the kept instruction
- out_instr  output  INSTR_WIDTH  encoding of the kept instruction
- out_class  output  4  one-hot class of the kept instruction; 0 if it was kept by the window or by bypass
- out_post  output  1  instruction was kept because of the post-event window
- kept_count  output  STAT_WIDTH  number of instructions captured into the output register
- lost_count  output  STAT_WIDTH  number of kept instructions discarded because the output register was full

Behaviour:
- Reset: all outputs and internal state are cleared to 0, including out_valid, both statistics counters and the window counter.
- Classification is combinational on in_instr. At most one class matches.
  - branch: [6:0]==1100011; or [1:0]==01 with [15:14]==11 (c.beqz/c.bnez).
  - jump: [6:0]==1101111 or 1100111; or [1:0]==01 with [15:13] equal to 001 or 101; or [1:0]==10 with [15:13]==100, [6:2]==0 and [11:7]!=0.
  - wfi: in_instr==32'h10500073.
  - xret: in_instr==32'h30200073 (mret) or 32'h10200073 (sret).
- Keep decision, evaluated only when in_valid=1:
  - event: the matched class has its class_enable bit set.
  - window: win_cnt!=0 and the instruction is not an event.
  - keep = bypass | event | window.
- Window counter (win_cnt, POST_CNT_WIDTH bits), updated only on in_valid cycles:
  - On an event whose class also has post_enable set: win_cnt is loaded with post_count. This reloads a window already in progress; it does not accumulate.
  - On a window keep: win_cnt is decremented by 1.
  - Otherwise win_cnt holds its value.
  - The counter is updated while bypass=1, even though bypass forces the keep.
  - post_count=0 means no window is opened.
  - Deasserting post_enable does not cancel a window already in progress.
- Config inputs (class_enable, post_enable, post_count, bypass) are sampled on the same cycle as in_valid. There is no shadowing.
- Output stage: one register, 1-cycle latency from in_valid to out_valid.
  - A transfer occurs when out_valid & out_ready.
  - A kept instruction is captured when out_valid==0 or out_ready==1. A transfer and a capture may happen in the same cycle, giving back-to-back throughput of 1 per cycle.
  - On capture, kept_count increments by 1.
  - If the register is full and out_ready==0, the new kept instruction is discarded. lost_count increments by 1, and out_* is unchanged.
  - When a transfer occurs without a capture, out_valid goes to 0.
  - out_pc, out_instr, out_class and out_post change only on capture.
- Both statistics counters saturate at all-ones and never wrap.
- Reset asserted mid-window or with a pending output: everything clears on that edge, and the pending output is not counted as lost.

Test Plan:
- Window reload:
  - Stimulus: class_enable=4'b0001, post_enable=4'b0001, post_count=2, out_ready=1. Sequence: addi, beq, addi, addi, addi.
  - Required: exactly the beq (out_class=0001) and the next two addi (out_post=1) are output, each 1 cycle after its input; kept_count=3.
  - Stimulus: a second beq placed during the window.
  - Required: the window is reloaded to 2 and is not extended further.
- Compressed decode:
  - Stimulus: in_instr set in turn to c.bnez, c.j, c.jalr (x1), c.jr with rs1=0, and wfi, with class_enable=4'b1111.
  - Required: out_class is 0001, 0010, 0010 and 0100 respectively; the rs1=0 encoding is dropped.
- xret with no window:
  - Stimulus: mret with post_enable=0, followed by 3 addi.
  - Required: only mret is output (out_class=1000).
- Backpressure:
  - Stimulus: out_ready=0 and 3 consecutive branches.
  - Required: the first branch is held in the output register; lost_count=2; kept_count=1.
  - Stimulus: out_ready then raised for one cycle while a 4th branch arrives.
  - Required: a transfer and a capture happen in the same cycle, and out_pc equals the 4th branch's PC.
- Bypass and idle gaps:
  - Stimulus: bypass=1 with in_valid toggling 1,0,1.
  - Required: exactly 2 outputs.
  - Stimulus: an in_valid=0 gap placed inside a window.
  - Required: win_cnt holds during the gap.
- Reset and saturation:
  - Stimulus: rst pulsed while out_valid=1 and win_cnt=3.
  - Required: on the next cycle out_valid=0, both counters are 0, and the next addi is dropped.
  - Stimulus: with STAT_WIDTH=2, lose 5 instructions.
  - Required: lost_count stays at 3.
